// File: rtl/fft_bfly_pipe.sv
// fft_bfly_pipe: radix-2 FFT butterfly, three register stages.
//   S1 forms a+b and a-b and captures the twiddle (conjugated in inverse mode).
//   S2 rotates a-b by the twiddle with round-half-up back to input scale.
//   S3 slices the output window, saturating or wrapping, and flags overflow.
// The whole pipe advances together whenever the output slot is empty or
// being drained, so in_ready is a pure function of v3 and out_ready.
module fft_bfly_pipe #(
  parameter int IW        = 32,
  parameter int OW        = 16,
  parameter int TW        = 18,
  parameter int OSHIFT    = 8,
  parameter int SAT       = 1,
  parameter int FRAME_LEN = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*IW-1:0] i0,
  input  logic [2*IW-1:0] i1,
  input  logic [2*TW-1:0] tw,
  input  logic            inv,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*OW-1:0] o0,
  output logic [2*OW-1:0] o1,
  output logic            out_last,
  output logic            ovf
);

  // SW: add/sub width, PW: full product width, XW: common width fed to the slicer
  localparam int SW = IW + 1;
  localparam int PW = IW + TW + 2;
  localparam int XW = IW + 4;
  localparam int HB = OSHIFT + OW - 1;
  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
  // half an output LSB of the rotated result, for round-half-up
  localparam logic [PW-1:0] RND = {{(PW - TW + 2){1'b0}}, 1'b1, {(TW - 3){1'b0}}};

  logic adv;
  logic v1, v2, v3;
  logic [CW-1:0] cnt;

  // input unpacking, {re, im}
  logic [IW-1:0] a_re, a_im, b_re, b_im;
  logic [TW-1:0] w_re, w_im;
  logic [SW-1:0] a_re_x, a_im_x, b_re_x, b_im_x;
  logic [TW:0]   w_im_x;

  assign a_re = i0[2*IW-1:IW];
  assign a_im = i0[IW-1:0];
  assign b_re = i1[2*IW-1:IW];
  assign b_im = i1[IW-1:0];
  assign w_re = tw[2*TW-1:TW];
  assign w_im = tw[TW-1:0];

  assign a_re_x = {a_re[IW-1], a_re};
  assign a_im_x = {a_im[IW-1], a_im};
  assign b_re_x = {b_re[IW-1], b_re};
  assign b_im_x = {b_im[IW-1], b_im};
  // one extra bit so that negating -2.0 stays representable
  assign w_im_x = {w_im[TW-1], w_im};

  assign adv       = !v3 || out_ready;
  assign in_ready  = adv;
  assign out_valid = v3;
  assign out_last  = v3 && (cnt == LAST);

  // S1 registers
  logic [SW-1:0] s1_sr, s1_si, s1_dr, s1_di;
  logic [TW-1:0] s1_wr;
  logic [TW:0]   s1_wi;

  // S1: butterfly add/sub and twiddle capture, conj(W) when inv is set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      s1_sr <= '0;
      s1_si <= '0;
      s1_dr <= '0;
      s1_di <= '0;
      s1_wr <= '0;
      s1_wi <= '0;
    end else if (adv) begin
      v1    <= in_valid;
      s1_sr <= a_re_x + b_re_x;
      s1_si <= a_im_x + b_im_x;
      s1_dr <= a_re_x - b_re_x;
      s1_di <= a_im_x - b_im_x;
      s1_wr <= w_re;
      s1_wi <= inv ? -w_im_x : w_im_x;
    end
  end

  // complex multiply at full precision; the low PW bits of the product do not
  // depend on signedness, so plain sign-extended operands are enough
  logic [PW-1:0] dr_x, di_x, wr_x, wi_x;
  logic [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic [PW-1:0] rot_re, rot_im;

  assign dr_x = {{(PW - SW){s1_dr[SW-1]}}, s1_dr};
  assign di_x = {{(PW - SW){s1_di[SW-1]}}, s1_di};
  assign wr_x = {{(PW - TW){s1_wr[TW-1]}}, s1_wr};
  assign wi_x = {{(PW - TW - 1){s1_wi[TW]}}, s1_wi};

  assign p_rr = dr_x * wr_x;
  assign p_ii = di_x * wi_x;
  assign p_ri = dr_x * wi_x;
  assign p_ir = di_x * wr_x;

  assign rot_re = p_rr - p_ii + RND;
  assign rot_im = p_ri + p_ir + RND;

  // fraction bits dropped by the twiddle renormalisation
  logic unused_rot_lsbs;
  assign unused_rot_lsbs = ^{rot_re[TW-3:0], rot_im[TW-3:0]};

  // S2 registers, all sign-extended to the common slicer width
  logic [XW-1:0] s2_sr, s2_si, s2_rr, s2_ri;

  // S2: rotate the difference, pass the sum through
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2    <= 1'b0;
      s2_sr <= '0;
      s2_si <= '0;
      s2_rr <= '0;
      s2_ri <= '0;
    end else if (adv) begin
      v2    <= v1;
      s2_sr <= {{(XW - SW){s1_sr[SW-1]}}, s1_sr};
      s2_si <= {{(XW - SW){s1_si[SW-1]}}, s1_si};
      // arithmetic shift right by TW-2 is exactly this upper slice
      s2_rr <= rot_re[PW-1:TW-2];
      s2_ri <= rot_im[PW-1:TW-2];
    end
  end

  if (OSHIFT > 0) begin : g_lsb_sink
    logic unused_slice_lsbs;
    assign unused_slice_lsbs = ^{s2_sr[OSHIFT-1:0], s2_si[OSHIFT-1:0],
                                 s2_rr[OSHIFT-1:0], s2_ri[OSHIFT-1:0]};
  end

  // returns {overflow, OW-bit result}; v is the source with the LSBs below
  // the output window already removed
  function automatic logic [OW:0] slice_out(input logic [XW-OSHIFT-1:0] v);
    logic [XW-1-HB:0] hi;
    logic             over;
    logic [OW-1:0]    d;
    hi   = v[XW-OSHIFT-1:OW-1];
    over = !((&hi) || !(|hi));
    d    = v[OW-1:0];
    if (over && (SAT != 0)) begin
      d = v[XW-OSHIFT-1] ? {1'b1, {(OW - 1){1'b0}}} : {1'b0, {(OW - 1){1'b1}}};
    end
    return {over, d};
  endfunction

  logic [OW:0] q_sr, q_si, q_rr, q_ri;
  logic        any_over;

  assign q_sr     = slice_out(s2_sr[XW-1:OSHIFT]);
  assign q_si     = slice_out(s2_si[XW-1:OSHIFT]);
  assign q_rr     = slice_out(s2_rr[XW-1:OSHIFT]);
  assign q_ri     = slice_out(s2_ri[XW-1:OSHIFT]);
  assign any_over = q_sr[OW] | q_si[OW] | q_rr[OW] | q_ri[OW];

  // S3: output slice registers and sticky overflow from valid beats only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3  <= 1'b0;
      o0  <= '0;
      o1  <= '0;
      ovf <= 1'b0;
    end else if (adv) begin
      v3 <= v2;
      o0 <= {q_sr[OW-1:0], q_si[OW-1:0]};
      o1 <= {q_rr[OW-1:0], q_ri[OW-1:0]};
      if (v2 && any_over) begin
        ovf <= 1'b1;
      end
    end
  end

  // frame beat counter, advances only on an actual output transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (v3 && out_ready) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_fft_bfly_pipe.sv
// Directed bench for fft_bfly_pipe: a saturating and a wrapping instance share
// one stimulus stream; expected values are hand-computed constants or simple
// closed-form formulas of the beat index.
module tb_fft_bfly_pipe;

  localparam int FL = 16;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [63:0] i0, i1;
  logic [35:0] tw;
  logic        inv;
  logic        out_ready;

  logic        in_ready, out_valid, out_last, ovf;
  logic [31:0] o0, o1;
  logic        w_in_ready, w_out_valid, w_out_last, w_ovf;
  logic [31:0] w_o0, w_o1;

  int total = 0;
  int bad   = 0;

  fft_bfly_pipe #(.IW(32), .OW(16), .TW(18), .OSHIFT(8), .SAT(1), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .i0(i0), .i1(i1), .tw(tw), .inv(inv),
    .out_valid(out_valid), .out_ready(out_ready), .o0(o0), .o1(o1),
    .out_last(out_last), .ovf(ovf)
  );

  fft_bfly_pipe #(.IW(32), .OW(16), .TW(18), .OSHIFT(8), .SAT(0), .FRAME_LEN(FL)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .i0(i0), .i1(i1), .tw(tw), .inv(inv),
    .out_valid(w_out_valid), .out_ready(out_ready), .o0(w_o0), .o1(w_o1),
    .out_last(w_out_last), .ovf(w_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // presents one pair for one cycle and walks to the cycle its result is due
  task automatic send_one(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [35:0] w, input logic iv);
    in_valid = 1'b1; i0 = a; i1 = b; tw = w; inv = iv; out_ready = 1'b1;
    #1 check({tag, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0; i0 = '0; i1 = '0; tw = '0; inv = 1'b0;
    check({tag, "_lat1"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_lat2"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_lat3"}, out_valid, 1);
  endtask

  // stream stimulus for beat k: a = (k+1, k/2), b = (1, 0), W = +1 or -1
  function automatic logic [63:0] vec_a(input int k);
    logic [31:0] re, im;
    re = 32'((k + 1) * 65536);
    im = 32'(k * 32768);
    return {re, im};
  endfunction

  function automatic logic [31:0] exp_o0(input int k);
    logic [15:0] re, im;
    re = 16'((k + 2) * 256);
    im = 16'(k * 128);
    return {re, im};
  endfunction

  function automatic logic [31:0] exp_o1(input int k);
    logic [15:0] re, im;
    int s;
    s  = (k % 2 == 1) ? -1 : 1;
    re = 16'(s * k * 256);
    im = 16'(s * k * 128);
    return {re, im};
  endfunction

  // streams n beats with optional bubbles/stalls; a reference occupancy model
  // predicts out_valid and in_ready, and inputs are scrambled whenever the
  // block is not accepting
  task automatic stream(input string tag, input int n, input int bub_pct,
                        input int stl_pct, input bit first_stall);
    int  sent, got, cyc, stall_left;
    bit  did_stall, mv1, mv2, mv3, adv_m;
    sent = 0; got = 0; cyc = 0; stall_left = 0; did_stall = 0;
    mv1 = 0; mv2 = 0; mv3 = 0;
    while (got < n && cyc < 600) begin
      if (first_stall && !did_stall && mv3) begin
        stall_left = 4;
        did_stall  = 1;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = ($urandom_range(99) >= stl_pct);
      end
      if (sent < n && $urandom_range(99) >= bub_pct) begin
        in_valid = 1'b1;
        i0  = vec_a(sent);
        i1  = {32'h0001_0000, 32'h0};
        tw  = (sent % 2 == 1) ? {18'h30000, 18'h0} : {18'h10000, 18'h0};
        inv = sent[0];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      adv_m = !mv3 || out_ready;
      check({tag, "_out_valid"}, out_valid, mv3);
      check({tag, "_in_ready"}, in_ready, adv_m);
      if (mv3) begin
        check({tag, "_o0"}, o0, exp_o0(got));
        check({tag, "_o1"}, o1, exp_o1(got));
        check({tag, "_out_last"}, out_last, (got % FL == FL - 1));
        if (out_ready) got++;
      end
      if (!adv_m) begin
        i0 = '1; i1 = '0; tw = {18'h0, 18'h10000}; inv = 1'b1;
      end
      if (adv_m) begin
        mv3 = mv2; mv2 = mv1; mv1 = in_valid;
        if (in_valid) sent++;
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, "_beats"}, got, n);
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; i0 = '0; i1 = '0; tw = '0; inv = 1'b0; out_ready = 1'b1;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_o0", o0, 0);
    check("rst_o1", o1, 0);
    check("rst_out_last", out_last, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // a = (3,1), b = (1,2), W = 1: o0 = (4,3), o1 = (2,-1)
    send_one("basic", {32'h0003_0000, 32'h0001_0000}, {32'h0001_0000, 32'h0002_0000},
             {18'h10000, 18'h0}, 1'b0);
    check("basic_o0", o0, 32'h0400_0300);
    check("basic_o1", o1, 32'h0200_FF00);
    check("basic_wrap_o0", w_o0, 32'h0400_0300);
    @(negedge clk);
    check("basic_one_beat", out_valid, 0);

    // W = -j: (2,-1)*(-j) = (-1,-2)
    send_one("twj", {32'h0003_0000, 32'h0001_0000}, {32'h0001_0000, 32'h0002_0000},
             {18'h0, 18'h30000}, 1'b0);
    check("twj_o1", o1, 32'hFF00_FE00);
    @(negedge clk);

    // inverse: conj(-j) = +j, (2,-1)*j = (1,2)
    send_one("twj_inv", {32'h0003_0000, 32'h0001_0000}, {32'h0001_0000, 32'h0002_0000},
             {18'h0, 18'h30000}, 1'b1);
    check("twj_inv_o1", o1, 32'h0100_0200);
    check("twj_inv_o0", o0, 32'h0400_0300);
    @(negedge clk);

    // 0x1FF * 0.5 = 0xFF.8, rounds up to 0x100, one output LSB
    send_one("round", {32'h0000_01FF, 32'h0}, 64'h0, {18'h08000, 18'h0}, 1'b0);
    check("round_o1", o1, 32'h0001_0000);
    check("round_o0", o0, 32'h0001_0000);
    check("no_ovf_yet", ovf, 0);
    check("no_ovf_yet_wrap", w_ovf, 0);
    @(negedge clk);

    // 127.0 + 127.0 = 254.0 exceeds the +128 window
    send_one("pos_sat", {32'h007F_0000, 32'h0}, {32'h007F_0000, 32'h0}, {18'h10000, 18'h0}, 1'b0);
    check("pos_sat_o0", o0, 32'h7FFF_0000);
    check("pos_wrap_o0", w_o0, 32'hFE00_0000);
    check("pos_sat_o1", o1, 32'h0);
    check("pos_wrap_o1", w_o1, 32'h0);
    check("pos_sat_ovf", ovf, 1);
    check("pos_wrap_ovf", w_ovf, 1);
    check("pos_wrap_valid", w_out_valid, 1);
    @(negedge clk);

    // -127.0 + -127.0 = -254.0
    send_one("neg_sat", {32'hFF81_0000, 32'h0}, {32'hFF81_0000, 32'h0}, {18'h10000, 18'h0}, 1'b0);
    check("neg_sat_o0", o0, 32'h8000_0000);
    check("neg_wrap_o0", w_o0, 32'h0200_0000);
    @(negedge clk);

    // ovf is sticky across clean beats
    send_one("sticky", {32'h0003_0000, 32'h0001_0000}, {32'h0001_0000, 32'h0002_0000},
             {18'h10000, 18'h0}, 1'b0);
    check("sticky_o0", o0, 32'h0400_0300);
    check("sticky_ovf", ovf, 1);
    check("sticky_wrap_ovf", w_ovf, 1);
    check("sticky_wrap_last", w_out_last, 0);
    check("sticky_wrap_ready", w_in_ready, 1);
    @(negedge clk);

    do_reset();
    check("ovf_cleared", ovf, 0);

    // 5 back-to-back pairs, output held off for 4 cycles at the first result
    stream("stall", 5, 0, 0, 1'b1);

    do_reset();
    // two frames with random bubbles and stalls
    stream("frame", 2 * FL, 25, 25, 1'b0);

    // three pairs in flight, then reset
    out_ready = 1'b1;
    in_valid = 1'b1; i0 = {32'h007F_0000, 32'h0}; i1 = {32'h007F_0000, 32'h0};
    tw = {18'h10000, 18'h0}; inv = 1'b0;
    @(negedge clk);
    i0 = vec_a(0); i1 = {32'h0001_0000, 32'h0};
    @(negedge clk);
    i0 = vec_a(2);
    @(negedge clk);
    in_valid = 1'b0;
    check("flight_valid", out_valid, 1);
    check("flight_ovf", ovf, 1);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_o0", o0, 0);
    check("midrst_o1", o1, 0);
    check("midrst_ovf", ovf, 0);
    check("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_no_valid", out_valid, 0);
    end
    check("post_rst_ovf", ovf, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
